// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// master: controller side (drives control, reads IR fields and memory ready).
// slave:  datapath side.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic [1:0]       RegDst;
    logic [1:0]       MemtoReg;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSrc;
    logic             ExtOp;
    logic             LuOp;
    logic [3:0]       ALUOp;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic             mem_timeout;

    modport master (
        input  OpCode, Funct, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
        output RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ExtOp, LuOp, ALUOp,
        output state, retired, mem_timeout
    );

    modport slave (
        output OpCode, Funct, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
        input  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ExtOp, LuOp, ALUOp,
        input  state, retired, mem_timeout
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB, counts retired
// instructions and flags stuck memory handshakes with a sticky watchdog.
// Optional feature: define MULTICYCLE_CTRL_EXC_EN to trap undefined opcodes
// into an exception state instead of treating them as NOPs.
module multicycle_control #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WAIT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        StIf   = 4'd0,
        StId   = 4'd1,
        StExr  = 4'd2,
        StWbr  = 4'd3,
        StExi  = 4'd4,
        StWbi  = 4'd5,
        StAddr = 4'd6,
        StMrd  = 4'd7,
        StMwr  = 4'd8,
        StWbm  = 4'd9,
        StBr   = 4'd10,
        StJ    = 4'd11,
        StJr   = 4'd12,
        StExc  = 4'd13
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic [5:0] op;
    logic [5:0] fn;
    logic       ext_op;
    logic       lu_op;
    logic       waiting;

    assign op = bus.OpCode;
    assign fn = bus.Funct;

    // Immediate extension mode depends only on the opcode held in IR.
    always_comb begin
        ext_op = 1'b0;
        case (op)
            6'h23, 6'h2b, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b: ext_op = 1'b1;
            default:                                         ext_op = 1'b0;
        endcase
        lu_op = (op == 6'h0f);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIf;
        else       state_q <= state_d;
    end

    // Next-state logic including the ID dispatch decoder.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIf:  state_d = bus.mem_ready ? StId : StIf;
            StId: begin
                case (op)
                    6'h00:        state_d = (fn == 6'h08 || fn == 6'h09) ? StJr : StExr;
                    6'h23, 6'h2b: state_d = StAddr;
                    6'h04:        state_d = StBr;
                    6'h02, 6'h03: state_d = StJ;
                    6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: state_d = StExi;
`ifdef MULTICYCLE_CTRL_EXC_EN
                    default:      state_d = StExc;
`else
                    // Undefined opcode retires as a NOP.
                    default:      state_d = StIf;
`endif
                endcase
            end
            StExr:  state_d = StWbr;
            StWbr:  state_d = StIf;
            StExi:  state_d = StWbi;
            StWbi:  state_d = StIf;
            StAddr: state_d = (op == 6'h23) ? StMrd : StMwr;
            StMrd:  state_d = bus.mem_ready ? StWbm : StMrd;
            StMwr:  state_d = bus.mem_ready ? StIf : StMwr;
            StWbm:  state_d = StIf;
            StBr:   state_d = StIf;
            StJ:    state_d = StIf;
            StJr:   state_d = StIf;
            StExc:  state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    // Moore control outputs; only IRWrite/PCWrite in IF look at mem_ready.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 2'b00;
        bus.MemtoReg    = 2'b00;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSrc       = 2'b00;
        bus.ALUOp       = 4'b0000;
        // Extension controls stay valid for the whole instruction after IF.
        bus.ExtOp       = (state_q != StIf) ? ext_op : 1'b0;
        bus.LuOp        = (state_q != StIf) ? lu_op : 1'b0;
        case (state_q)
            StIf: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            StId: begin
                bus.ALUSrcB = 2'b11;
            end
            StExr: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = {op[0], 3'b010};
            end
            StWbr: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 2'b01;
            end
            StExi: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (op)
                    6'h0c:        bus.ALUOp = {op[0], 3'b100};
                    6'h0a, 6'h0b: bus.ALUOp = {op[0], 3'b101};
                    default:      bus.ALUOp = {op[0], 3'b000};
                endcase
            end
            StWbi: begin
                bus.RegWrite = 1'b1;
            end
            StAddr: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            StMrd: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            StMwr: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            StWbm: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b01;
            end
            StBr: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 4'b0001;
                bus.PCWriteCond = 1'b1;
                bus.PCSrc       = 2'b01;
            end
            StJ: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 2'b10;
                if (op == 6'h03) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'b10;
                    bus.MemtoReg = 2'b10;
                end
            end
            StJr: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 2'b11;
                if (fn == 6'h09) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'b01;
                    bus.MemtoReg = 2'b10;
                end
            end
            StExc: begin
                // Handler address arrives through the rs path; link to $ra.
                bus.PCWrite  = 1'b1;
                bus.PCSrc    = 2'b11;
                bus.RegWrite = 1'b1;
                bus.RegDst   = 2'b10;
                bus.MemtoReg = 2'b10;
            end
            default: ;
        endcase
    end

    // Retire count and memory-wait watchdog next-state.
    always_comb begin
        retired_d = retired_q;
        if (state_q != StIf && state_q != StExc && state_d == StIf) begin
            retired_d = retired_q + CNT_W'(1);
        end
        waiting = (state_q == StIf || state_q == StMrd || state_q == StMwr) && !bus.mem_ready;
        if (!waiting)             wait_d = '0;
        else if (wait_q == '1)    wait_d = wait_q;
        else                      wait_d = wait_q + WAIT_W'(1);
        timeout_d = timeout_q | (wait_d == '1);
    end

    // Counter and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            retired_q <= retired_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.retired     = retired_q;
    assign bus.mem_timeout = timeout_q;

endmodule
